// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display path.
package display_pkg;

  localparam int          DIGITS   = 8;
  localparam logic [31:0] MAX_DEC  = 32'd99_999_999;
  localparam logic [31:0] OVF_CODE = 32'hEEEE_EEEE;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/display_source_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  nibble_t adj;

  // Wraps within 4 bits; digits never exceed 9 for in-range inputs.
  assign adj     = digit_i + 4'd3;
  assign digit_o = (digit_i >= 4'd5) ? adj : digit_i;

endmodule

// File: rtl/display_source.sv
// Captures a value on load and presents it as hex or as 8 packed BCD digits
// (sequential double-dabble), updating data_out only when a result is complete.
module display_source
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        mode_dec,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  state_t      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [31:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] data_out_q, data_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [31:0] bcd_adj;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .digit_i(bcd_q[4*gi +: 4]),
        .digit_o(bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (!mode_dec) begin
            data_out_d = data_in;
            ovf_d      = 1'b0;
            done_d     = 1'b1;
          end else if (data_in > MAX_DEC) begin
            data_out_d = OVF_CODE;
            ovf_d      = 1'b1;
            done_d     = 1'b1;
          end else begin
            bin_d   = data_in;
            bcd_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[30:0], bin_q[31]};
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        data_out_d = bcd_q;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_display_source.sv
// Self-checking bench for display_source: table vectors, hand sequences and
// randomized requests against an arithmetic decimal-digit reference model.
module tb_display_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        mode_dec = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [31:0] MAXV = 32'd99_999_999;
  localparam logic [31:0] EEEE = 32'hEEEE_EEEE;

  display_source dut (
    .clk(clk), .reset(reset), .load(load), .mode_dec(mode_dec),
    .data_in(data_in), .data_out(data_out), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] v;
    logic [31:0] exp_d;
    logic        exp_o;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: decimal digits by repeated division, one nibble per digit.
  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_out(input logic m, input logic [31:0] v);
    if (!m) return v;
    if (v > MAXV) return EEEE;
    return to_bcd(v);
  endfunction

  // Waits for done, counting cycles since acceptance; checks data_out holds meanwhile.
  task automatic wait_done(inout int lat, input logic [31:0] prev, output logic held);
    held = 1'b1;
    while (!done && lat < 200) begin
      if (data_out !== prev) held = 1'b0;
      if (busy !== 1'b1) held = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic run_req(input logic m, input logic [31:0] v, input logic [31:0] exp_d,
                         input logic exp_o, input int exp_lat, input string tag);
    logic [31:0] prev;
    logic        held;
    int          lat;
    prev     = data_out;
    mode_dec = m;
    data_in  = v;
    load     = 1'b1;
    step();
    load    = 1'b0;
    data_in = $urandom();
    lat     = 1;
    check({tag, " busy_first"}, {31'd0, busy}, {31'd0, exp_lat > 1});
    wait_done(lat, prev, held);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data_out"}, data_out, exp_d);
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_o});
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    if (exp_lat > 1) check({tag, " hold_during_busy"}, {31'd0, held}, 32'd1);
    step();
    check({tag, " done_single"}, {31'd0, done}, 32'd0);
    $display("txn %s mode=%0d in=%h out=%h ovf=%0d lat=%0d", tag, m, v, data_out, overflow, lat);
  endtask

  initial begin
    logic        held;
    int          lat;
    logic        rm;
    logic [31:0] rv;

    tbl[0] = '{1'b0, 32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 1};
    tbl[1] = '{1'b1, 32'd12_345_678, 32'h1234_5678, 1'b0, 34};
    tbl[2] = '{1'b1, 32'd0,          32'h0000_0000, 1'b0, 34};
    tbl[3] = '{1'b1, 32'd99_999_999, 32'h9999_9999, 1'b0, 34};
    tbl[4] = '{1'b1, 32'd100_000_000, 32'hEEEE_EEEE, 1'b1, 1};
    tbl[5] = '{1'b0, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1};
    tbl[6] = '{1'b1, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 1'b1, 1};
    tbl[7] = '{1'b1, 32'd5,          32'h0000_0005, 1'b0, 34};

    // Reset state
    step();
    check("reset data_out", data_out, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].m, tbl[i].v, tbl[i].exp_d, tbl[i].exp_o, tbl[i].lat, $sformatf("tbl%0d", i));
    end

    // Load while busy is ignored
    mode_dec = 1'b1; data_in = 32'd12_345_678; load = 1'b1;
    step();
    load = 1'b0;
    lat = 1;
    repeat (8) begin step(); lat++; end
    data_in = 32'd5; load = 1'b1;
    step(); lat++;
    load = 1'b0;
    wait_done(lat, 32'h0000_0005, held);
    check("busyload latency", lat, 34);
    check("busyload data_out", data_out, 32'h1234_5678);
    $display("txn busyload out=%h lat=%0d", data_out, lat);
    step();
    run_req(1'b1, 32'd5, 32'h0000_0005, 1'b0, 34, "after_busy");

    // Asynchronous reset in the middle of a conversion
    mode_dec = 1'b1; data_in = 32'd12_345_678; load = 1'b1;
    step();
    load = 1'b0;
    repeat (14) step();
    #2 reset = 1'b1;
    #1;
    check("midrst data_out", data_out, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst overflow", {31'd0, overflow}, 32'd0);
    $display("txn midreset out=%h busy=%0d", data_out, busy);
    step();
    reset = 1'b0;
    step();
    run_req(1'b1, 32'd42, 32'h0000_0042, 1'b0, 34, "post_reset");

    // Back-to-back hex loads
    mode_dec = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      data_in = k; load = 1'b1;
      step();
      check($sformatf("b2b%0d data_out", k), data_out, k);
      check($sformatf("b2b%0d done", k), {31'd0, done}, 32'd1);
      $display("txn b2b%0d out=%h done=%0d", k, data_out, done);
    end
    load = 1'b0;
    step();
    check("b2b done_low", {31'd0, done}, 32'd0);

    // Randomized requests against the reference model
    for (int r = 0; r < 24; r++) begin
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rv = $urandom();
        1:       rv = MAXV + 32'($urandom_range(0, 2));
        default: rv = $urandom_range(0, 99_999_999);
      endcase
      run_req(rm, rv, model_out(rm, rv), rm && (rv > MAXV),
              (rm && rv <= MAXV) ? 34 : 1, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
